// File: rtl/cci_mpf_shim_buffer_lockstep_nchan_if.sv
// Bundles the request-side and head-side signals of the lock-step N-channel buffer.
// Latency: none; this is wiring only.
// Backpressure: upstream (master) watches full/almost_full; the buffer (slave) drives them.
// The optional peak_occupancy signal exists only when CCI_MPF_LOCKSTEP_STATS_EN is defined.
interface cci_mpf_shim_buffer_lockstep_nchan_if #(
  parameter int N_CHANNELS = 2,
  parameter int DATA_BITS  = 64,
  parameter int N_ENTRIES  = 6
);
  localparam int OCC_W = $clog2(N_ENTRIES + 1);

  logic [N_CHANNELS-1:0]           enq_valid;
  logic [N_CHANNELS*DATA_BITS-1:0] enq_data;
  logic                            deq_en;
  logic                            not_empty;
  logic [N_CHANNELS-1:0]           first_valid;
  logic [N_CHANNELS*DATA_BITS-1:0] first_data;
  logic                            full;
  logic                            almost_full;
  logic [OCC_W-1:0]                occupancy;
  logic                            overflow_err;
  logic                            underflow_err;
`ifdef CCI_MPF_LOCKSTEP_STATS_EN
  logic [OCC_W-1:0]                peak_occupancy;
`endif

  // Requester / dequeuing-stage side
  modport master (
    output enq_valid, enq_data, deq_en,
    input  not_empty, first_valid, first_data, full, almost_full, occupancy,
    input  overflow_err, underflow_err
`ifdef CCI_MPF_LOCKSTEP_STATS_EN
    , input peak_occupancy
`endif
  );

  // Buffer side
  modport slave (
    input  enq_valid, enq_data, deq_en,
    output not_empty, first_valid, first_data, full, almost_full, occupancy,
    output overflow_err, underflow_err
`ifdef CCI_MPF_LOCKSTEP_STATS_EN
    , output peak_occupancy
`endif
  );
endinterface

// File: rtl/cci_mpf_shim_buffer_lockstep_nchan.sv
// Lock-step N-channel request FIFO: one entry carries every channel's payload plus a valid mask.
// Latency: an entry written in cycle t appears on first_* in cycle t+1 (no bypass).
// Backpressure: full drops requests (sticky overflow_err); almost_full gives THRESHOLD slots slack.
// Optional feature macro: CCI_MPF_LOCKSTEP_STATS_EN adds a peak_occupancy high-water mark.
module cci_mpf_shim_buffer_lockstep_nchan #(
  parameter int N_CHANNELS = 2,
  parameter int DATA_BITS  = 64,
  parameter int N_ENTRIES  = 6,
  parameter int THRESHOLD  = 4
) (
  input logic clk,
  input logic reset,
  cci_mpf_shim_buffer_lockstep_nchan_if.slave buf_if
);
  localparam int OCC_W  = $clog2(N_ENTRIES + 1);
  localparam int PTR_W  = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
  localparam int WIDTH  = N_CHANNELS * DATA_BITS;
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(N_ENTRIES);
  localparam logic [OCC_W-1:0] OCC_THR  = OCC_W'(THRESHOLD);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_ENTRIES - 1);

  // Storage is deliberately not reset; the head is masked to zero whenever empty.
  logic [N_CHANNELS-1:0] valid_mem [N_ENTRIES];
  logic [WIDTH-1:0]      data_mem  [N_ENTRIES];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;

  logic any_enq;
  logic is_full;
  logic is_empty;
  logic do_enq;
  logic do_deq;
  logic [OCC_W-1:0] free_slots;

  // Depth need not be a power of two, so wrap by explicit compare.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Status comes from registered occupancy only, so deq_en never reaches full combinationally.
  assign any_enq    = |buf_if.enq_valid;
  assign is_full    = (occ_q == OCC_MAX);
  assign is_empty   = (occ_q == '0);
  assign do_enq     = any_enq && !is_full;
  assign do_deq     = buf_if.deq_en && !is_empty;
  assign free_slots = OCC_MAX - occ_q;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    ovf_d    = ovf_q | (any_enq && is_full);
    udf_d    = udf_q | (buf_if.deq_en && is_empty);
    if (do_enq) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_enq, do_deq})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state register; reset discards every held entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Entry write: mask and all payloads land in one slot so channels never split.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      valid_mem[wr_ptr_q] <= buf_if.enq_valid;
      data_mem[wr_ptr_q]  <= buf_if.enq_data;
    end
  end

  assign buf_if.not_empty     = !is_empty;
  assign buf_if.first_valid   = is_empty ? '0 : valid_mem[rd_ptr_q];
  assign buf_if.first_data    = is_empty ? '0 : data_mem[rd_ptr_q];
  assign buf_if.full          = is_full;
  assign buf_if.almost_full   = (free_slots <= OCC_THR);
  assign buf_if.occupancy     = occ_q;
  assign buf_if.overflow_err  = ovf_q;
  assign buf_if.underflow_err = udf_q;

`ifdef CCI_MPF_LOCKSTEP_STATS_EN
  logic [OCC_W-1:0] peak_q;

  // High-water mark of occupancy; bounded by N_ENTRIES since occupancy is.
  always_ff @(posedge clk) begin
    if (reset) peak_q <= '0;
    else if (occ_d > peak_q) peak_q <= occ_d;
  end

  assign buf_if.peak_occupancy = peak_q;
`endif
endmodule

// File: tb/tb_cci_mpf_shim_buffer_lockstep_nchan.sv
module tb_cci_mpf_shim_buffer_lockstep_nchan;
  localparam int NC = 2;
  localparam int DB = 8;
  localparam int NE = 6;
  localparam int TH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cci_mpf_shim_buffer_lockstep_nchan_if #(.N_CHANNELS(NC), .DATA_BITS(DB), .N_ENTRIES(NE)) bus ();

  cci_mpf_shim_buffer_lockstep_nchan #(
    .N_CHANNELS(NC), .DATA_BITS(DB), .N_ENTRIES(NE), .THRESHOLD(TH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .buf_if (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock with the given inputs; the queue model tracks what should be held.
  task automatic cyc(input logic [1:0] v, input logic [15:0] d, input logic deq);
    int sz;
    bus.enq_valid = v;
    bus.enq_data  = d;
    bus.deq_en    = deq;
    sz = exp_q.size();
    @(posedge clk);
    if (!reset) begin
      if (deq && sz > 0) void'(exp_q.pop_front());
      if (v != 2'b00 && sz < NE) exp_q.push_back(d);
    end else begin
      exp_q.delete();
    end
    #1;
    bus.enq_valid = '0;
    bus.enq_data  = '0;
    bus.deq_en    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.enq_valid = '0;
    bus.enq_data  = '0;
    bus.deq_en    = 1'b0;

    // 1: reset state
    cyc(2'b00, 16'h0, 1'b0);
    cyc(2'b00, 16'h0, 1'b0);
    reset = 1'b0;
    chk("rst_not_empty", bus.not_empty, 0);
    chk("rst_first_valid", bus.first_valid, 0);
    chk("rst_first_data", bus.first_data, 0);
    chk("rst_occ", bus.occupancy, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_almost_full", bus.almost_full, 0);
    chk("rst_ovf", bus.overflow_err, 0);
    chk("rst_udf", bus.underflow_err, 0);

    // 2: partial masks, one-cycle latency, almost_full at two entries
    cyc(2'b01, 16'h00A5, 1'b0);
    chk("t2_fv1", bus.first_valid, 2'b01);
    chk("t2_fd1", bus.first_data, 16'h00A5);
    chk("t2_occ1", bus.occupancy, 1);
    chk("t2_af1", bus.almost_full, 0);
    cyc(2'b10, 16'h3C00, 1'b0);
    chk("t2_occ2", bus.occupancy, 2);
    chk("t2_af2", bus.almost_full, 1);
    chk("t2_head_kept", bus.first_data, 16'h00A5);
    cyc(2'b00, 16'h0, 1'b1);
    chk("t2_fd_after_deq", bus.first_data, 16'h3C00);
    chk("t2_fv_after_deq", bus.first_valid, 2'b10);
    chk("t2_occ_after_deq", bus.occupancy, 1);
    cyc(2'b00, 16'h0, 1'b1);
    chk("t2_drained", bus.not_empty, 0);

    // 3: fill to full, then enqueue while full with a simultaneous dequeue
    for (int k = 1; k <= 6; k++) cyc(2'b11, 16'h1100 + 16'(k), 1'b0);
    chk("t3_full", bus.full, 1);
    chk("t3_occ6", bus.occupancy, 6);
`ifdef CCI_MPF_LOCKSTEP_STATS_EN
    chk("t3_peak", bus.peak_occupancy, 6);
`endif
    cyc(2'b11, 16'hDEAD, 1'b1);
    chk("t3_ovf", bus.overflow_err, 1);
    chk("t3_occ5", bus.occupancy, 5);
    chk("t3_full_clr", bus.full, 0);
    chk("t3_udf_clean", bus.underflow_err, 0);
    chk("t3_head", bus.first_data, 16'h1102);
    cyc(2'b00, 16'h0, 1'b1);
    cyc(2'b00, 16'h0, 1'b1);
    chk("t3_occ3", bus.occupancy, 3);
    chk("t3_head4", bus.first_data, 16'h1104);

    // 4: steady enq+deq at occupancy 3 across several pointer wraps
    for (int i = 0; i < 10; i++) begin
      cyc(2'b11, 16'h2000 + 16'(i), 1'b1);
      chk("t4_occ", bus.occupancy, 3);
      chk("t4_head", bus.first_data, 32'(exp_q[0]));
    end
    chk("t4_head_final", bus.first_data, 16'h2007);
    for (int i = 0; i < 3; i++) begin
      chk("t4_drain", bus.first_data, 16'h2007 + 16'(i));
      cyc(2'b00, 16'h0, 1'b1);
    end
    chk("t4_empty", bus.not_empty, 0);
    chk("t4_model_empty", 32'(exp_q.size()), 0);

    // 5: dequeue while empty, and an idle enqueue mask
    cyc(2'b00, 16'h0, 1'b1);
    chk("t5_udf", bus.underflow_err, 1);
    chk("t5_occ", bus.occupancy, 0);
    chk("t5_fv", bus.first_valid, 0);
    cyc(2'b00, 16'hFFFF, 1'b0);
    chk("t5_idle_occ", bus.occupancy, 0);
    chk("t5_idle_ne", bus.not_empty, 0);
    chk("t5_ovf_sticky", bus.overflow_err, 1);
    chk("t5_udf_sticky", bus.underflow_err, 1);

    // 6: reset in the middle of operation
    for (int k = 0; k < 4; k++) cyc(2'b01, 16'h0040 + 16'(k), 1'b0);
    chk("t6_occ4", bus.occupancy, 4);
    reset = 1'b1;
    cyc(2'b00, 16'h0, 1'b0);
    reset = 1'b0;
    chk("t6_occ0", bus.occupancy, 0);
    chk("t6_ne", bus.not_empty, 0);
    chk("t6_fv", bus.first_valid, 0);
    chk("t6_fd", bus.first_data, 0);
    chk("t6_ovf", bus.overflow_err, 0);
    chk("t6_udf", bus.underflow_err, 0);
`ifdef CCI_MPF_LOCKSTEP_STATS_EN
    chk("t6_peak", bus.peak_occupancy, 0);
`endif
    cyc(2'b11, 16'h5A5A, 1'b0);
    chk("t6_post_fd", bus.first_data, 16'h5A5A);
    chk("t6_post_occ", bus.occupancy, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
